// File: rtl/ifft4.sv
// 4-point inverse DFT built as two radix-2 stages with a start/done handshake.
// Define IFFT4_ROUND_EN for round-half-up scaling; otherwise the /4 truncates toward -inf.
module ifft4 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3
);
    localparam int H = WIDTH / 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_STG1 = 2'd1;
    localparam logic [1:0] ST_STG2 = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

`ifdef IFFT4_ROUND_EN
    localparam logic [H+1:0] BIAS = (H+2)'(2);
`else
    localparam logic [H+1:0] BIAS = '0;
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] in_bus [4];
    logic [WIDTH-1:0] x_q    [4];
    logic [H:0]       xr     [4];
    logic [H:0]       xi     [4];
    // First-stage butterflies: index 0..3 hold a, b, c, d
    logic [H:0]       p_re_d [4];
    logic [H:0]       p_im_d [4];
    logic [H:0]       p_re_q [4];
    logic [H:0]       p_im_q [4];
    logic [H+1:0]     pe_re  [4];
    logic [H+1:0]     pe_im  [4];
    logic [H+1:0]     s_re   [4];
    logic [H+1:0]     s_im   [4];
    logic [H+1:0]     r_re   [4];
    logic [H+1:0]     r_im   [4];
    logic [WIDTH-1:0] y_d    [4];
    logic [WIDTH-1:0] y_q    [4];

    assign in_bus[0] = in0;
    assign in_bus[1] = in1;
    assign in_bus[2] = in2;
    assign in_bus[3] = in3;

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = start ? ST_STG1 : ST_IDLE;
            ST_STG1: state_d = ST_STG2;
            ST_STG2: state_d = ST_OUT;
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // a = X0+X2, b = X0-X2, c = X1+X3, d = X1-X3
    assign p_re_d[0] = xr[0] + xr[2];
    assign p_im_d[0] = xi[0] + xi[2];
    assign p_re_d[1] = xr[0] - xr[2];
    assign p_im_d[1] = xi[0] - xi[2];
    assign p_re_d[2] = xr[1] + xr[3];
    assign p_im_d[2] = xi[1] + xi[3];
    assign p_re_d[3] = xr[1] - xr[3];
    assign p_im_d[3] = xi[1] - xi[3];

    // Inverse twiddle on the odd pair is +j: j*d = (-d.im, d.re)
    assign s_re[0] = pe_re[0] + pe_re[2];
    assign s_im[0] = pe_im[0] + pe_im[2];
    assign s_re[2] = pe_re[0] - pe_re[2];
    assign s_im[2] = pe_im[0] - pe_im[2];
    assign s_re[1] = pe_re[1] - pe_im[3];
    assign s_im[1] = pe_im[1] + pe_re[3];
    assign s_re[3] = pe_re[1] + pe_im[3];
    assign s_im[3] = pe_im[1] - pe_re[3];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign xr[gi]    = {x_q[gi][WIDTH-1], x_q[gi][WIDTH-1:H]};
            assign xi[gi]    = {x_q[gi][H-1], x_q[gi][H-1:0]};
            assign pe_re[gi] = {p_re_q[gi][H], p_re_q[gi]};
            assign pe_im[gi] = {p_im_q[gi][H], p_im_q[gi]};
            // S spans H+2 bits, so the biased value cannot wrap and S/4 fits in H bits
            assign r_re[gi]  = s_re[gi] + BIAS;
            assign r_im[gi]  = s_im[gi] + BIAS;
            assign y_d[gi]   = {H'(r_re[gi] >> 2), H'(r_im[gi] >> 2)};

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    x_q[gi]    <= '0;
                    p_re_q[gi] <= '0;
                    p_im_q[gi] <= '0;
                    y_q[gi]    <= '0;
                end else begin
                    if (state_q == ST_IDLE && start) begin
                        x_q[gi] <= in_bus[gi];
                    end
                    if (state_q == ST_STG1) begin
                        p_re_q[gi] <= p_re_d[gi];
                        p_im_q[gi] <= p_im_d[gi];
                    end
                    if (state_q == ST_STG2) begin
                        y_q[gi] <= y_d[gi];
                    end
                end
            end
        end
    endgenerate

    // Results land on the edge entering OUT, so done and valid data coincide
    assign done = (state_q == ST_OUT);
    assign busy = (state_q != ST_IDLE);
    assign out0 = y_q[0];
    assign out1 = y_q[1];
    assign out2 = y_q[2];
    assign out3 = y_q[3];

endmodule

// File: tb/tb_ifft4.sv
// Scoreboard bench for ifft4: driver pushes DFT-model results, monitor checks on done.
module tb_ifft4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic        done, busy;
    logic [31:0] out0, out1, out2, out3;

    int n_vec  = 0;
    int n_miss = 0;
    logic [127:0] exp_q[$];

    ifft4 #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .done(done), .busy(busy),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input int re, input int im);
        logic [15:0] r, i;
        r = re[15:0];
        i = im[15:0];
        return {r, i};
    endfunction

    // x[n] = (1/4) * sum_k X[k] * j^(k*n), scaled per component
    function automatic logic [127:0] model(input logic [127:0] xs);
        logic [127:0] res;
        logic [31:0]  w;
        longint sr, si, xr, xi, qr, qi;
        int m;
        res = '0;
        for (int n = 0; n < 4; n++) begin
            sr = 0;
            si = 0;
            for (int k = 0; k < 4; k++) begin
                w  = xs[32*k +: 32];
                xr = longint'($signed(w[31:16]));
                xi = longint'($signed(w[15:0]));
                m  = (k * n) % 4;
                case (m)
                    0: begin sr += xr; si += xi; end
                    1: begin sr -= xi; si += xr; end
                    2: begin sr -= xr; si -= xi; end
                    default: begin sr += xi; si -= xr; end
                endcase
            end
`ifdef IFFT4_ROUND_EN
            sr += 2;
            si += 2;
`endif
            qr = sr >>> 2;
            qi = si >>> 2;
            res[32*n +: 32] = {qr[15:0], qi[15:0]};
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    initial begin
        logic [127:0] e;
        forever begin
            @(negedge clk);
            if (rst && done) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_done: got done with no pending transform at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", {out3, out2, out1, out0}, e);
                    $display("xform out=%h exp=%h", {out3, out2, out1, out0}, e);
                end
            end
        end
    end

    task automatic load(input logic [127:0] xs);
        in0 = xs[31:0];
        in1 = xs[63:32];
        in2 = xs[95:64];
        in3 = xs[127:96];
    endtask

    task automatic scramble();
        load({$urandom(), $urandom(), $urandom(), $urandom()});
    endtask

    // Called in the low phase; returns at the negedge after done (back in IDLE)
    task automatic issue(input logic [127:0] xs);
        load(xs);
        start = 1'b1;
        exp_q.push_back(model(xs));
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                scramble();
            end
            chk("busy_done_timeline", {126'd0, busy, done}, {126'd0, 1'b1, (k == 3)});
        end
        @(negedge clk);
        chk("idle_after_done", {126'd0, busy, done}, 128'd0);
    endtask

    initial begin
        logic [127:0] xs;
        #1 rst = 1'b0;
        #11;
        chk("reset_outputs", {out3, out2, out1, out0}, 128'd0);
        chk("reset_flags", {126'd0, busy, done}, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        issue({pk(0, 0), pk(0, 0), pk(0, 0), pk(4, 0)});
        issue({pk(0, 0), pk(0, 0), pk(4, 0), pk(0, 0)});
        issue({pk(0, 0), pk(0, 0), pk(0, 0), pk(2, 0)});
`ifdef IFFT4_ROUND_EN
        chk("half_pos_out0_re", {112'd0, out0[31:16]}, {112'd0, 16'd1});
`else
        chk("half_pos_out0_re", {112'd0, out0[31:16]}, {112'd0, 16'd0});
`endif
        issue({pk(0, 0), pk(0, 0), pk(0, 0), pk(-2, 0)});
`ifdef IFFT4_ROUND_EN
        chk("half_neg_out0_re", {112'd0, out0[31:16]}, {112'd0, 16'd0});
`else
        chk("half_neg_out0_re", {112'd0, out0[31:16]}, {112'd0, 16'hffff});
`endif
        issue({4{pk(32767, -32768)}});
        chk("extreme_direct", {out3, out2, out1, out0},
            {pk(0, 0), pk(0, 0), pk(0, 0), pk(32767, -32768)});

        // start re-asserted during the first two busy cycles must be ignored
        xs = {$urandom(), $urandom(), $urandom(), $urandom()};
        load(xs);
        start = 1'b1;
        exp_q.push_back(model(xs));
        @(negedge clk);
        scramble();
        chk("overlap_busy1", {126'd0, busy, done}, {126'd0, 2'b10});
        @(negedge clk);
        scramble();
        chk("overlap_busy2", {126'd0, busy, done}, {126'd0, 2'b10});
        @(negedge clk);
        start = 1'b0;
        chk("overlap_done", {126'd0, busy, done}, {126'd0, 2'b11});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("overlap_no_second", {126'd0, busy, done}, 128'd0);
        end

        // reset in the middle of a transform aborts it
        xs = {$urandom(), $urandom(), $urandom(), $urandom()};
        load(xs);
        start = 1'b1;
        exp_q.push_back(model(xs));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset_outputs", {out3, out2, out1, out0}, 128'd0);
        chk("midreset_flags", {126'd0, busy, done}, 128'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("postreset_idle", {126'd0, busy, done}, 128'd0);
        end
        issue({pk(0, 0), pk(0, 0), pk(0, 0), pk(4, 0)});

        // randomized back-to-back transforms at full throughput
        for (int t = 0; t < 40; t++) begin
            issue({$urandom(), $urandom(), $urandom(), $urandom()});
        end

        chk("scoreboard_drained", {96'd0, 32'(exp_q.size())}, 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
